// File: rtl/pmu_pkg.sv
// Shared constants, counter type and flattened-bus helper for the PMU event-counter bank.
package pmu_pkg;

    localparam int PMU_N_COUNTERS = 24;
    localparam int PMU_REG_WIDTH  = 32;

    typedef logic [PMU_REG_WIDTH-1:0] cnt_t;

    // Bit offset of counter idx inside the flattened counter bus.
    function automatic int cnt_slice(input int idx, input int width = PMU_REG_WIDTH);
        return idx * width;
    endfunction

endpackage

// File: rtl/pmu_counter.sv
// One PMU event counter with its sticky overflow flag.
// The overflow flag is only built when PMU_OVERFLOW_EN is defined.
module pmu_counter #(
    parameter int REG_WIDTH = pmu_pkg::PMU_REG_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 softrst_i,
    input  logic                 we_i,
    input  logic [REG_WIDTH-1:0] wdata_i,
    input  logic                 inc_i,
    input  logic                 ovf_clr_i,
    output logic [REG_WIDTH-1:0] cnt_o,
    output logic                 ovf_o
);

    logic [REG_WIDTH-1:0] cnt_q;

    // Soft clear beats preload, preload beats the event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (softrst_i) begin
            cnt_q <= '0;
        end else if (we_i) begin
            cnt_q <= wdata_i;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

`ifdef PMU_OVERFLOW_EN
    logic ovf_q;
    logic wrap;

    // Only an increment that actually lands can wrap the counter.
    assign wrap = inc_i && !we_i && !softrst_i && (cnt_q == {REG_WIDTH{1'b1}});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (softrst_i) begin
            ovf_q <= 1'b0;
        end else if (wrap) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf_o = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr_i;
    assign ovf_o          = 1'b0;
`endif

endmodule

// File: rtl/pmu_counters.sv
// PMU event-counter bank: N_COUNTERS counters with preload, soft clear and an
// optional overflow/interrupt path enabled by the PMU_OVERFLOW_EN macro.
module pmu_counters
    import pmu_pkg::*;
#(
    parameter  int N_COUNTERS = PMU_N_COUNTERS,
    parameter  int REG_WIDTH  = PMU_REG_WIDTH,
    localparam int IDX_W      = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_COUNTERS-1:0]           events_i,
    input  logic [N_COUNTERS-1:0]           en_i,
    input  logic                            softrst_i,
    input  logic                            we_i,
    input  logic [IDX_W-1:0]                widx_i,
    input  logic [REG_WIDTH-1:0]            wdata_i,
    input  logic [N_COUNTERS-1:0]           ovf_clr_i,
    input  logic [N_COUNTERS-1:0]           ovf_mask_i,
    output logic [N_COUNTERS*REG_WIDTH-1:0] counter_o,
    output logic [N_COUNTERS-1:0]           ovf_o,
    output logic                            intr_o
);

    logic [N_COUNTERS-1:0] we_dec;
    logic [N_COUNTERS-1:0] inc;
    logic [N_COUNTERS-1:0] ovf;

    for (genvar i = 0; i < N_COUNTERS; i++) begin : g_cnt
        // An out-of-range index matches no counter, so the preload is dropped.
        assign we_dec[i] = we_i && (int'(widx_i) == i);
        assign inc[i]    = en_i[i] && events_i[i];

        pmu_counter #(
            .REG_WIDTH(REG_WIDTH)
        ) u_counter (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .softrst_i(softrst_i),
            .we_i     (we_dec[i]),
            .wdata_i  (wdata_i),
            .inc_i    (inc[i]),
            .ovf_clr_i(ovf_clr_i[i]),
            .cnt_o    (counter_o[cnt_slice(i, REG_WIDTH) +: REG_WIDTH]),
            .ovf_o    (ovf[i])
        );
    end

    assign ovf_o = ovf;

`ifdef PMU_OVERFLOW_EN
    logic intr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            intr_q <= 1'b0;
        end else begin
            intr_q <= |(ovf & ovf_mask_i);
        end
    end

    assign intr_o = intr_q;
`else
    logic unused_mask;
    assign unused_mask = ^ovf_mask_i;
    assign intr_o      = 1'b0;
`endif

endmodule

// File: tb/tb_pmu_counters.sv
// Self-checking bench for pmu_counters: directed scenarios plus randomized
// traffic compared every cycle against a rule-level reference model.
module tb_pmu_counters;
    import pmu_pkg::*;

    localparam int N  = PMU_N_COUNTERS;
    localparam int W  = PMU_REG_WIDTH;
    localparam int IW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      events;
    logic [N-1:0]      en;
    logic              softrst;
    logic              we;
    logic [IW-1:0]     widx;
    logic [W-1:0]      wdata;
    logic [N-1:0]      ovf_clr;
    logic [N-1:0]      ovf_mask;
    logic [N*W-1:0]    counter;
    logic [N-1:0]      ovf;
    logic              intr;

    // Reference state
    logic [W-1:0]      m_cnt [N];
    logic [N-1:0]      m_ovf;
    logic              m_intr;

    int vec_count  = 0;
    int miss_count = 0;

`ifdef PMU_OVERFLOW_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    pmu_counters dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .events_i  (events),
        .en_i      (en),
        .softrst_i (softrst),
        .we_i      (we),
        .widx_i    (widx),
        .wdata_i   (wdata),
        .ovf_clr_i (ovf_clr),
        .ovf_mask_i(ovf_mask),
        .counter_o (counter),
        .ovf_o     (ovf),
        .intr_o    (intr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miss_count++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] dut_cnt(input int i);
        return counter[i*W +: W];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = '0;
        m_ovf  = '0;
        m_intr = 1'b0;
    endtask

    // Applies one clock edge's worth of the block's rules to the model.
    task automatic model_edge();
        logic [N-1:0] nxt_ovf;
        m_intr  = OVF_ON && ((m_ovf & ovf_mask) != '0);
        nxt_ovf = m_ovf;
        for (int i = 0; i < N; i++) begin
            if (softrst) begin
                m_cnt[i]   = '0;
                nxt_ovf[i] = 1'b0;
            end else if (we && int'(widx) == i) begin
                m_cnt[i] = wdata;
                if (ovf_clr[i]) nxt_ovf[i] = 1'b0;
            end else if (en[i] && events[i]) begin
                if (m_cnt[i] == {W{1'b1}}) begin
                    m_cnt[i]   = '0;
                    nxt_ovf[i] = OVF_ON;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                    if (ovf_clr[i]) nxt_ovf[i] = 1'b0;
                end
            end else if (ovf_clr[i]) begin
                nxt_ovf[i] = 1'b0;
            end
        end
        m_ovf = nxt_ovf;
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) check($sformatf("cnt%0d", i), 64'(dut_cnt(i)), 64'(m_cnt[i]));
        check("ovf", 64'(ovf), 64'(m_ovf));
        check("intr", 64'(intr), 64'(m_intr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        events = '0; en = '0; softrst = 1'b0; we = 1'b0;
        widx = '0; wdata = '0; ovf_clr = '0; ovf_mask = '0;
    endtask

    task automatic preload(input int idx, input logic [W-1:0] val);
        we = 1'b1; widx = IW'(idx); wdata = val;
        tick();
        we = 1'b0;
    endtask

    initial begin
        logic [W-1:0] snap [N];
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        #3 rst = 1'b0;

        // Reset mid-count: counter 0 at 57, async reset clears it at once.
        preload(0, 32'd57);
        check("pre_rst_cnt0", 64'(dut_cnt(0)), 64'd57);
        en[0] = 1'b1; events[0] = 1'b1;
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_cnt0", 64'(dut_cnt(0)), 64'd0);
        check("async_rst_ovf", 64'(ovf), 64'd0);
        check("async_rst_intr", 64'(intr), 64'd0);
        @(posedge clk); #1;
        compare_all();
        idle_inputs();
        #2 rst = 1'b0;

        // Counting: enabled counter 0 counts, disabled counter 1 does not.
        en[0] = 1'b1; events[0] = 1'b1; events[1] = 1'b1;
        repeat (10) tick();
        events = '0;
        check("count_cnt0", 64'(dut_cnt(0)), 64'd10);
        check("count_cnt1", 64'(dut_cnt(1)), 64'd0);
        en = '0;

        // Preload beats a same-cycle event.
        en[2] = 1'b1; events[2] = 1'b1;
        preload(2, 32'h100);
        check("preload_cnt2", 64'(dut_cnt(2)), 64'h100);
        tick();
        check("preload_inc_cnt2", 64'(dut_cnt(2)), 64'h101);
        idle_inputs();

        // Wrap of counter 3 with interrupt enabled.
        ovf_mask[3] = 1'b1;
        preload(3, 32'hFFFF_FFFF);
        en[3] = 1'b1; events[3] = 1'b1;
        tick();
        events[3] = 1'b0;
        check("wrap_cnt3", 64'(dut_cnt(3)), 64'd0);
        check("wrap_ovf3", 64'(ovf[3]), 64'(OVF_ON));
        check("wrap_intr_same_edge", 64'(intr), 64'd0);
        tick();
        check("wrap_intr_next_edge", 64'(intr), 64'(OVF_ON));
        ovf_clr[3] = 1'b1;
        tick();
        ovf_clr[3] = 1'b0;
        check("clr_ovf3", 64'(ovf[3]), 64'd0);
        tick();
        check("clr_intr", 64'(intr), 64'd0);

        // Soft clear beats preload.
        preload(1, 32'h1234);
        softrst = 1'b1;
        preload(1, 32'h55);
        softrst = 1'b0;
        check("softrst_we_cnt1", 64'(dut_cnt(1)), 64'd0);

        // Clear on the same edge as a fresh wrap: the set wins.
        preload(3, 32'hFFFF_FFFF);
        events[3] = 1'b1;
        tick();
        events[3] = 1'b0;
        preload(3, 32'hFFFF_FFFF);
        events[3] = 1'b1; ovf_clr[3] = 1'b1;
        tick();
        events[3] = 1'b0; ovf_clr[3] = 1'b0;
        check("clr_vs_wrap_ovf3", 64'(ovf[3]), 64'(OVF_ON));

        // Out-of-range preload index touches nothing.
        for (int i = 0; i < N; i++) snap[i] = dut_cnt(i);
        en = '0;
        preload(N, 32'hDEAD_BEEF);
        for (int i = 0; i < N; i++) check($sformatf("oor_cnt%0d", i), 64'(dut_cnt(i)), 64'(snap[i]));
        idle_inputs();

        // Randomized traffic, near-max preloads to provoke wraps.
        for (int k = 0; k < 400; k++) begin
            events   = N'($urandom);
            en       = N'($urandom) | N'($urandom);
            softrst  = ($urandom_range(0, 49) == 0);
            we       = ($urandom_range(0, 4) == 0);
            widx     = IW'($urandom_range(0, N + 3));
            case ($urandom_range(0, 3))
                0: wdata = '1;
                1: wdata = '1 - W'($urandom_range(1, 3));
                default: wdata = W'($urandom);
            endcase
            ovf_clr  = N'($urandom) & N'($urandom) & N'($urandom);
            ovf_mask = N'($urandom);
            tick();
        end
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
